clk_meas: RTL and testbench

- Synthesizable receive-side counterpart to the bench clock/pulse generators: measures an asynchronous periodic input against the system clock.
- Reports high time, low time, period and phase offset in clk cycles, for checking generated clocks/strobes in-system and in benches.
- Raises a stuck flag when the input stops toggling.

---
 rtl/clk_meas.sv | 189 ++++++++++++++++++
 tb/tb_clk_meas.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_meas.sv
// Measures high time, low time, period and phase of an asynchronous periodic input
// in system-clock cycles, and flags an input that has stopped toggling.
module clk_meas #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    input  logic             ref_tick,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period_cnt,
    output logic [CNT_W-1:0] phase_cnt,
    output logic             phase_valid,
    output logic             ovf,
    output logic             stuck
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   sig_s, rise, fall;
    logic [CNT_W-1:0]       hcnt_q, hcnt_d, lcnt_q, lcnt_d;
    logic                   ovfp_q, ovfp_d;
    logic [TO_W-1:0]        sil_q, sil_d;
    logic                   latch, timeout;
    logic [CNT_W-1:0]       pcnt_q, pcnt_nxt, ph_pend_q;
    logic                   seen_q, phv_pend_q;

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~edge_q;
    assign fall  = ~sig_s & edge_q;

    // Synchronizer and edge-detect flop run regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            edge_q <= sig_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            lcnt_q  <= '0;
            ovfp_q  <= 1'b0;
            sil_q   <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            lcnt_q  <= lcnt_d;
            ovfp_q  <= ovfp_d;
            sil_q   <= sil_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d = state_q;
        hcnt_d  = hcnt_q;
        lcnt_d  = lcnt_q;
        ovfp_d  = ovfp_q;
        sil_d   = sil_q;
        latch   = 1'b0;
        timeout = 1'b0;
        if (!en) begin
            state_d = IDLE;
            hcnt_d  = '0;
            lcnt_d  = '0;
            ovfp_d  = 1'b0;
            sil_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sil_d = '0;
                    if (rise) begin
                        state_d = HIGH;
                        hcnt_d  = CNT_ONE;
                        lcnt_d  = '0;
                        ovfp_d  = 1'b0;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d = LOW;
                        lcnt_d  = CNT_ONE;
                    end else if (hcnt_q == CNT_MAX) begin
                        ovfp_d = 1'b1;
                    end else begin
                        hcnt_d = hcnt_q + CNT_ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        latch   = 1'b1;
                        state_d = HIGH;
                        hcnt_d  = CNT_ONE;
                        lcnt_d  = '0;
                        ovfp_d  = 1'b0;
                    end else if (lcnt_q == CNT_MAX) begin
                        ovfp_d = 1'b1;
                    end else begin
                        lcnt_d = lcnt_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
            // Silence timer only runs while a measurement is in progress.
            if (state_q != IDLE) begin
                if (rise || fall) begin
                    sil_d = '0;
                end else if (sil_q == TO_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                    hcnt_d  = '0;
                    lcnt_d  = '0;
                    ovfp_d  = 1'b0;
                    sil_d   = '0;
                end else begin
                    sil_d = sil_q + TO_ONE;
                end
            end
        end
    end

    // Phase counter value as of the end of this cycle; a coincident ref_tick yields 0.
    assign pcnt_nxt = ref_tick ? '0 : ((pcnt_q == CNT_MAX) ? CNT_MAX : pcnt_q + CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q     <= '0;
            seen_q     <= 1'b0;
            ph_pend_q  <= '0;
            phv_pend_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_nxt;
            if (ref_tick) seen_q <= 1'b1;
            if (en && rise) begin
                ph_pend_q  <= pcnt_nxt;
                phv_pend_q <= seen_q | ref_tick;
            end
        end
    end

    // The pending phase is read before being overwritten, so it travels with the period it opened.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid  <= 1'b0;
            high_cnt    <= '0;
            low_cnt     <= '0;
            period_cnt  <= '0;
            phase_cnt   <= '0;
            phase_valid <= 1'b0;
            ovf         <= 1'b0;
            stuck       <= 1'b0;
        end else begin
            meas_valid <= latch;
            if (latch) begin
                high_cnt    <= hcnt_q;
                low_cnt     <= lcnt_q;
                period_cnt  <= {1'b0, hcnt_q} + {1'b0, lcnt_q};
                phase_cnt   <= ph_pend_q;
                phase_valid <= phv_pend_q;
                ovf         <= ovfp_q;
                stuck       <= 1'b0;
            end else if (timeout) begin
                stuck <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_meas.sv
// Scoreboard bench for clk_meas: sig_in periods are driven 2 ns after clk edges and
// the expected result of each complete period is queued when its closing rise is driven.
module tb_clk_meas;

    localparam int CNT_W = 4;
    localparam int TO    = 50;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en = 1'b0;
    logic             sig_in = 1'b0;
    logic             ref_tick = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W:0]   period_cnt;
    logic [CNT_W-1:0] phase_cnt;
    logic             phase_valid;
    logic             ovf;
    logic             stuck;

    always #5 clk = ~clk;

    clk_meas #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sig_in     (sig_in),
        .ref_tick   (ref_tick),
        .meas_valid (meas_valid),
        .high_cnt   (high_cnt),
        .low_cnt    (low_cnt),
        .period_cnt (period_cnt),
        .phase_cnt  (phase_cnt),
        .phase_valid(phase_valid),
        .ovf        (ovf),
        .stuck      (stuck)
    );

    typedef struct {
        int h;
        int l;
        int ph;
        bit pv;
        bit ovf;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   cur_armed = 1'b0;
    bit   seen_tick = 1'b0;
    logic sig_prev  = 1'b0;
    int   cyc       = 0;
    int   last_tick = 0;
    int   rise_cyc  = -100;
    int   checks    = 0;
    int   errors    = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // One clk cycle of stimulus plus the bench's own bookkeeping of what it drove.
    task automatic step(input logic lvl, input logic tick);
        exp_t e;
        @(posedge clk);
        #2;
        sig_in   = lvl;
        ref_tick = tick;
        cyc++;
        if (tick) begin
            last_tick = cyc;
            seen_tick = 1'b1;
        end
        if (lvl && !sig_prev) begin
            if (cur_armed) begin
                check("sb_lag", q.size(), 0);
                e.h   = sat(cur.h);
                e.l   = sat(cur.l);
                e.ovf = (cur.h > CMAX) || (cur.l > CMAX);
                e.ph  = cur.ph;
                e.pv  = cur.pv;
                q.push_back(e);
            end
            cur       = '{h: 0, l: 0, ph: 0, pv: 1'b0, ovf: 1'b0};
            cur_armed = en;
            rise_cyc  = cyc;
        end
        if (lvl) cur.h++;
        else     cur.l++;
        // Two synchronizer stages separate the driven rise from the cycle it is detected in.
        if (cyc == rise_cyc + 2) begin
            cur.pv = seen_tick;
            cur.ph = sat(cyc - last_tick);
        end
        sig_prev = lvl;
    endtask

    task automatic drive(input int h, input int l, input int tick_idx);
        for (int i = 0; i < h + l; i++) step(i < h, i == tick_idx);
    endtask

    always @(negedge clk) begin
        if (rst_n && meas_valid) begin
            check("mv_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("high_cnt", high_cnt, e.h);
                check("low_cnt", low_cnt, e.l);
                check("period_cnt", period_cnt, e.h + e.l);
                check("ovf", ovf, e.ovf);
                check("phase_valid", phase_valid, e.pv);
                if (e.pv) check("phase_cnt", phase_cnt, e.ph);
                check("stuck_clr_on_mv", stuck, 0);
            end
        end
    end

    initial begin
        int mv_at;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_meas_valid", meas_valid, 0);
        check("rst_high", high_cnt, 0);
        check("rst_low", low_cnt, 0);
        check("rst_period", period_cnt, 0);
        check("rst_phase", phase_cnt, 0);
        check("rst_phase_valid", phase_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_stuck", stuck, 0);
        rst_n = 1'b1;
        en    = 1'b1;

        // Partial low, then 30% duty 200 ns periods with no ref_tick yet.
        repeat (7) step(1'b0, 1'b0);
        repeat (4) drive(6, 14, -1);

        // Phase: tick 7 cycles before detection, then tick coincident with detection.
        drive(6, 14, 15);
        drive(6, 14, -1);
        drive(6, 14, 2);
        drive(6, 14, -1);
        drive(6, 14, -1);

        // Saturating high phase, followed by normal periods.
        drive(40, 5, -1);
        drive(6, 14, -1);
        drive(6, 14, -1);

        // Stuck high after three good periods.
        repeat (3) drive(6, 14, -1);
        step(1'b1, 1'b0);
        mv_at = -1;
        for (int j = 1; j <= 80; j++) begin
            step(1'b1, 1'b0);
            if (meas_valid && mv_at < 0) mv_at = j;
            if (mv_at >= 0 && j == mv_at + TO - 1) check("stuck_early", stuck, 0);
            if (mv_at >= 0 && j == mv_at + TO) begin
                check("stuck_set", stuck, 1);
                check("stuck_hold_high", high_cnt, 6);
                check("stuck_hold_low", low_cnt, 14);
            end
        end
        check("stuck_mv_seen", mv_at >= 0 && mv_at < 80 - TO, 1);
        cur_armed = 1'b0;
        repeat (14) step(1'b0, 1'b0);
        drive(6, 14, -1);
        check("stuck_held_until_mv", stuck, 1);
        drive(6, 14, -1);
        drive(6, 14, -1);
        check("stuck_cleared", stuck, 0);

        // en dropped mid-HIGH, raised mid-LOW.
        drive(6, 14, -1);
        repeat (5) step(1'b1, 1'b0);
        en        = 1'b0;
        cur_armed = 1'b0;
        repeat (1) step(1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b0);
        en = 1'b1;
        repeat (7) step(1'b0, 1'b0);
        repeat (3) drive(6, 14, -1);

        // Reset asserted mid-LOW.
        repeat (6) step(1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b0);
        check("pre_rst_high", high_cnt, 6);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_meas_valid", meas_valid, 0);
        check("mid_rst_high", high_cnt, 0);
        check("mid_rst_low", low_cnt, 0);
        check("mid_rst_period", period_cnt, 0);
        check("mid_rst_phase", phase_cnt, 0);
        check("mid_rst_phase_valid", phase_valid, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_stuck", stuck, 0);
        cur_armed = 1'b0;
        check("sb_empty", q.size(), 0);
        #20 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
